// File: rtl/mult_control_pkg.sv
// Shared types for the shift-add multiplier control unit.
// State encodings, strobe bundle and the state-to-strobe decode.
package mult_control_pkg;

  localparam int N_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic load;
    logic ad;
    logic sh;
    logic done;
    logic busy;
  } ctrl_t;

  // Moore decode: strobes are one-hot or idle, busy covers LOAD..SHIFT
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_LOAD: begin
        c.load = 1'b1;
        c.busy = 1'b1;
      end
      S_TEST: begin
        c.busy = 1'b1;
      end
      S_ADD: begin
        c.ad   = 1'b1;
        c.busy = 1'b1;
      end
      S_SHIFT: begin
        c.sh   = 1'b1;
        c.busy = 1'b1;
      end
      S_DONE: begin
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_control_bit_counter.sv
// Iteration counter for the shift-add multiplier.
// Clear has priority over enable; tc flags the last iteration.
module mult_bit_counter #(
  parameter int N     = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Iteration index: cleared on load, stepped after each non-final shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mult_control.sv
// Control FSM of the shift-add multiplier.
// Drives Load/Ad/Sh for an external ACC and handshakes Done/St.
module mult_control
  import mult_control_pkg::*;
#(
  parameter  int N     = N_DEF,
  localparam int CNT_W = $clog2(N)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             St,
  input  logic             M,
  output logic             Load,
  output logic             Ad,
  output logic             Sh,
  output logic             Done,
  output logic             Busy,
  output logic [CNT_W-1:0] Count
);

  state_t state;
  ctrl_t  ctrl;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;

  // Counter control follows the registered state
  always_comb begin
    cnt_clr = (state == S_LOAD);
    cnt_en  = (state == S_SHIFT) && !cnt_tc;
  end

  mult_bit_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (Clk),
    .rst_n (Rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (Count),
    .tc    (cnt_tc)
  );

  // Sequencer: state and its decoded strobes are registered together
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      ctrl  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (St) begin
            state <= S_LOAD;
            ctrl  <= decode(S_LOAD);
          end
        end
        S_LOAD: begin
          state <= S_TEST;
          ctrl  <= decode(S_TEST);
        end
        S_TEST: begin
          if (M) begin
            state <= S_ADD;
            ctrl  <= decode(S_ADD);
          end else begin
            state <= S_SHIFT;
            ctrl  <= decode(S_SHIFT);
          end
        end
        S_ADD: begin
          state <= S_SHIFT;
          ctrl  <= decode(S_SHIFT);
        end
        S_SHIFT: begin
          if (cnt_tc) begin
            state <= S_DONE;
            ctrl  <= decode(S_DONE);
          end else begin
            state <= S_TEST;
            ctrl  <= decode(S_TEST);
          end
        end
        S_DONE: begin
          if (!St) begin
            state <= S_IDLE;
            ctrl  <= decode(S_IDLE);
          end
        end
        default: begin
          state <= S_IDLE;
          ctrl  <= '0;
        end
      endcase
    end
  end

  assign Load = ctrl.load;
  assign Ad   = ctrl.ad;
  assign Sh   = ctrl.sh;
  assign Done = ctrl.done;
  assign Busy = ctrl.busy;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control with a behavioural ACC and adder.
// Expected products/latencies are queued; a monitor pops on Done.
module tb_mult_control;

  localparam int N = 16;

  logic        Clk   = 1'b0;
  logic        Rst_n = 1'b1;
  logic        St    = 1'b0;
  logic        M;
  logic        Load, Ad, Sh, Done, Busy;
  logic [3:0]  Count;

  logic [15:0] mcand  = '0;
  logic [15:0] mplier = '0;
  logic [32:0] acc    = '0;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
    int          ads;
  } exp_t;

  exp_t q[$];
  exp_t e;

  bit   active    = 1'b0;
  bit   prev_done = 1'b0;
  int   cyc       = 0;
  int   ads       = 0;
  logic multi;

  always #5 Clk = ~Clk;

  assign M = acc[0];

  mult_control #(.N(N)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .St    (St),
    .M     (M),
    .Load  (Load),
    .Ad    (Ad),
    .Sh    (Sh),
    .Done  (Done),
    .Busy  (Busy),
    .Count (Count)
  );

  // 33-bit ACC with N-bit adder into the high half
  always @(posedge Clk) begin
    if (Load)
      acc <= {17'd0, mplier};
    else if (Ad)
      acc[32:16] <= {1'b0, acc[31:16]} + {1'b0, mcand};
    else if (Sh)
      acc <= acc >> 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: strobe exclusivity every cycle, result check on Done rise
  always @(negedge Clk) begin
    if (!Rst_n) begin
      active    = 1'b0;
      prev_done = 1'b0;
    end else begin
      multi = ($countones({Load, Ad, Sh, Done}) > 1);
      chk("strobe_onehot", {31'd0, multi}, 32'd0);
      if (Load) begin
        active = 1'b1;
        cyc    = 0;
        ads    = 0;
      end else if (active) begin
        cyc++;
        if (Ad) ads++;
      end
      if (Done && !prev_done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.cyc);
          chk("ad_pulses", ads, e.ads);
          chk("product", acc[31:0], e.prod);
          chk("acc_carry", {31'd0, acc[32]}, 32'd0);
        end
        active = 1'b0;
        pops++;
      end
      prev_done = Done;
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] p, input int c, input int n);
    exp_t x;
    x.prod = p;
    x.cyc  = c;
    x.ads  = n;
    q.push_back(x);
    mcand  = a;
    mplier = b;
  endtask

  task automatic wait_pops(input int target);
    int k;
    k = 0;
    while (pops < target && k < 200) begin
      @(negedge Clk);
      k++;
    end
    chk("done_seen", {31'd0, pops >= target}, 32'd1);
  endtask

  initial begin
    // 1: asynchronous reset, no clock edge yet
    #1 Rst_n = 1'b0;
    #1;
    chk("rst_strobes", {27'd0, Load, Ad, Sh, Done, Busy}, 32'd0);
    chk("rst_count", {28'd0, Count}, 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // 2: 5 x 3
    push(16'd5, 16'd3, 32'h0000000F, 35, 2);
    St = 1'b1;
    wait_pops(1);
    chk("done_count", {28'd0, Count}, 32'd15);
    St = 1'b0;
    @(negedge Clk);

    // 3: multiplier zero
    push(16'hABCD, 16'h0000, 32'h00000000, 33, 0);
    St = 1'b1;
    wait_pops(2);
    St = 1'b0;
    @(negedge Clk);

    // 4: all ones, then hold St in DONE
    push(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 49, 16);
    St = 1'b1;
    wait_pops(3);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("hold_done", {31'd0, Done}, 32'd1);
      chk("hold_noload", {31'd0, Load}, 32'd0);
      chk("hold_count", {28'd0, Count}, 32'd15);
    end

    // 5: release, back to IDLE, restart
    St = 1'b0;
    @(negedge Clk);
    chk("idle_done", {31'd0, Done}, 32'd0);
    chk("idle_busy", {31'd0, Busy}, 32'd0);
    push(16'h1234, 16'h0101, 32'h00124634, 35, 2);
    St = 1'b1;
    @(negedge Clk);
    chk("restart_load", {31'd0, Load}, 32'd1);
    wait_pops(4);
    St = 1'b0;
    @(negedge Clk);

    // St toggling while busy is ignored; St low at the end -> 1-cycle Done
    push(16'd7, 16'h8000, 32'h00038000, 34, 1);
    St = 1'b1;
    @(negedge Clk);
    chk("toggle_load", {31'd0, Load}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      St = ~St;
    end
    wait_pops(5);
    @(negedge Clk);
    chk("pulse_done_low", {31'd0, Done}, 32'd0);
    chk("pulse_idle", {31'd0, Busy}, 32'd0);

    // 6: reset during an ADD cycle (third iteration, Count=2)
    mcand  = 16'd9;
    mplier = 16'h0004;
    St = 1'b1;
    for (int k = 0; k < 100 && !Ad; k++) @(negedge Clk);
    chk("saw_add", {31'd0, Ad}, 32'd1);
    chk("add_count", {28'd0, Count}, 32'd2);
    #1 Rst_n = 1'b0;
    #1;
    chk("midrst_strobes", {27'd0, Load, Ad, Sh, Done, Busy}, 32'd0);
    chk("midrst_count", {28'd0, Count}, 32'd0);
    St = 1'b0;
    @(negedge Clk);
    #1 Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("post_rst_idle", {30'd0, Busy, Load}, 32'd0);
    end
    push(16'h00C3, 16'h0A0B, 32'h0007A661, 38, 5);
    St = 1'b1;
    wait_pops(6);
    St = 1'b0;
    repeat (2) @(negedge Clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
